// File: rtl/tri_pkg.sv
// tri_pkg: shared triangle types and fetch constants for triangle_fetch and pixel_shader
package tri_pkg;
  localparam int WORDS_PER_VERT = 4;
  localparam int VERTS = 3;
  localparam int WORDS_PER_TRI = WORDS_PER_VERT * VERTS;
  typedef logic [3:0][2:0][31:0] triangle_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} fetch_state_t;
  typedef struct packed {
    logic       valid;
    logic [1:0] w;
    logic [1:0] v;
  } rd_tag_t;
endpackage

// File: rtl/rd_delay_line.sv
// rd_delay_line: DEPTH-stage shift of read tags, aligning each tag with its BRAM return
//  clk_in/rst_in : clock, async active-high reset (clears all stages)
//  tag_in        : tag for the address presented this cycle
//  tag_out       : tag matching mem data arriving this cycle
module rd_delay_line
  import tri_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t [DEPTH-1:0] sr_q, sr_d;
  always_comb begin
    sr_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) sr_q <= '0;
    else sr_q <= sr_d;
  assign tag_out = sr_q[DEPTH-1];
endmodule

// File: rtl/triangle_fetch.sv
// triangle_fetch: reads 12-word triangles from BRAM and hands them one at a time to the shader
//  clk_in/rst_in    : clock, async active-high reset
//  start_in         : begin a frame of num_tris_in triangles at base_addr_in (ignored while busy)
//  mem_addr_out     : BRAM read address; mem_data_in returns MEM_LATENCY cycles later
//  triangle_out     : assembled triangle [w][v]; tri_valid_out pulses once per triangle
//  shader_done_in   : shader consumed the current triangle (only honoured while waiting)
//  busy_out/done_out: frame in progress / one-cycle frame-complete pulse
module triangle_fetch
  import tri_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_TRIS_W  = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_W-1:0]     base_addr_in,
  input  logic [MAX_TRIS_W-1:0] num_tris_in,
  output logic [ADDR_W-1:0]     mem_addr_out,
  input  logic [31:0]           mem_data_in,
  output triangle_t             triangle_out,
  output logic                  tri_valid_out,
  input  logic                  shader_done_in,
  output logic                  busy_out,
  output logic                  done_out
);
  localparam logic [3:0] NWORDS = 4'(WORDS_PER_TRI);
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_TRI - 1);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MAX_TRIS_W-1:0] num_q, num_d, tri_idx_q, tri_idx_d;
  logic [3:0] iss_q, iss_d;
  triangle_t tri_q, tri_d;
  logic busy_q, busy_d, done_q, done_d;
  logic issuing;
  rd_tag_t tag_in, tag_out;
  rd_delay_line #(.DEPTH(MEM_LATENCY)) u_dly (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );
  // Word k of a triangle sits at offset 4v+w, so w/v are just the low/high bit pairs of k.
  assign issuing = (state_q == S_FETCH) && (iss_q != NWORDS);
  assign tag_in  = '{valid: issuing, w: iss_q[1:0], v: iss_q[3:2]};
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    num_d     = num_q;
    tri_idx_d = tri_idx_q;
    iss_d     = iss_q;
    tri_d     = tri_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (tag_out.valid) tri_d[tag_out.w][tag_out.v] = mem_data_in;
    case (state_q)
      S_IDLE:
        if (start_in) begin
          num_d     = num_tris_in;
          tri_idx_d = '0;
          iss_d     = '0;
          if (num_tris_in == '0) done_d = 1'b1;
          else begin
            addr_d  = base_addr_in;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end
        end
      S_FETCH: begin
        if (issuing) begin
          iss_d = iss_q + 4'd1;
          // Hold on the 12th address so the next triangle continues at +1.
          if (iss_q != LAST_WORD) addr_d = addr_q + 1'b1;
        end
        if (tag_out.valid && tag_out.w == 2'd3 && tag_out.v == 2'd2) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:
        if (shader_done_in) begin
          tri_idx_d = tri_idx_q + 1'b1;
          if (tri_idx_d == num_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            iss_d   = '0;
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      num_q     <= '0;
      tri_idx_q <= '0;
      iss_q     <= '0;
      tri_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      num_q     <= num_d;
      tri_idx_q <= tri_idx_d;
      iss_q     <= iss_d;
      tri_q     <= tri_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  assign mem_addr_out  = addr_q;
  assign triangle_out  = tri_q;
  assign tri_valid_out = (state_q == S_ISSUE);
  assign busy_out      = busy_q;
  assign done_out      = done_q;
endmodule
